regfile_wr_arbiter: RTL

//  Round-robin arbiter that shares the single register-file write port among NUM_REQ writeback sources
//  (ALU, load, multiplier, ...).
//  The winner's address is registered and driven as wr_addr, which feeds the RegId input of the 6:64

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_pick.sv | 34 +++
 rtl/regfile_wr_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path: widths, the hard-wired
// zero register and the write-issue FSM encoding.
package regfile_pkg;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 16;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 6'd0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } wr_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searched circularly
// from ptr, returned as a one-hot grant plus its binary index.
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [2:0]         idx,
  output logic               any
);

  // Two ordered passes: positions at/after ptr first, then wrap to those below it.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && (i >= int'(ptr)) && req[i]) begin
        gnt[i] = 1'b1;
        idx    = 3'(i);
        any    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any && (i < int'(ptr)) && req[i]) begin
        gnt[i] = 1'b1;
        idx    = 3'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// NUM_REQ writeback sources, with freeze and register-0 write suppression.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      freeze,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [2:0]                grant_id,
  output logic [7:0]                drop_cnt
);

  // Handshake: requester i transfers in a cycle where req_valid[i] & req_ready[i];
  // req_ready is a one-hot subset of req_valid and is forced low during freeze or rst.

  wr_state_t            state_q, state_d;
  logic [2:0]           rr_ptr;
  logic [NUM_REQ-1:0]   gnt;
  logic [2:0]           gidx;
  logic                 gany;
  logic                 accept;
  logic                 zero_hit;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic [2:0]           ptr_next;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign req_ready = (rst || freeze) ? '0 : gnt;
  assign accept    = gany && !freeze && !rst;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign zero_hit = (sel_addr == ADDR_W'(ZERO_REG));
  assign ptr_next = (int'(gidx) == NUM_REQ - 1) ? 3'd0 : gidx + 3'd1;

  always_comb begin
    state_d = ST_IDLE;
    if (accept && !zero_hit) state_d = ST_ISSUE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // The ISSUE state is the registered write strobe itself.
  assign wr_en = (state_q == ST_ISSUE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      drop_cnt <= '0;
    end else if (accept) begin
      rr_ptr   <= ptr_next;
      grant_id <= gidx;
      if (zero_hit) begin
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

endmodule
